// File: rtl/params.sv
// params: shared job types, controller states, AXI bundles and cfg lookup functions for tc_seq_ctrl
package params;
  localparam int K_DIM = 16;
  localparam logic [15:0] CD_BITS = 16'd2048;
  localparam logic [7:0] BURST_SIZE = 8'd16;
  localparam logic [2:0] SEL_C = 3'b001;
  localparam logic [2:0] SEL_A = 3'b100;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_D = 3'b000;
  typedef enum logic [3:0] {
    FP32_m16n16k16, FP32_m8n32k16, FP32_m32n8k16,
    FP16_m16n16k16, FP16_m8n32k16, FP16_m32n8k16,
    INT8_m16n16k16, INT8_m8n32k16, INT8_m32n8k16,
    INT4_m16n16k16, INT4_m8n32k16, INT4_m32n8k16
  } full_type_t;
  localparam logic [3:0] CFG_MAX = 4'd11;
  typedef enum logic [2:0] {
    IDLE, READ_C, WAIT_A, WAIT_B, SYSTOLIC, ACCUMULATE, WRITE_BACK, FINISH
  } state_t;
  typedef struct packed {
    logic        request_valid;
    logic [2:0]  sel;
    logic [15:0] recvbits;
    logic [7:0]  burst_size;
    logic [7:0]  burst_num;
    logic [15:0] a_base;
    logic [15:0] b_base;
    logic [15:0] c_base;
    logic [15:0] d_base;
  } AXI_out_t;
  typedef struct packed {
    logic finish;
  } AXI_in_t;
  function automatic int shape_of(full_type_t t);
    return int'(t) % 3;
  endfunction
  function automatic int m_dim(full_type_t t);
    return shape_of(t) == 0 ? 16 : shape_of(t) == 1 ? 8 : 32;
  endfunction
  function automatic int n_dim(full_type_t t);
    return shape_of(t) == 0 ? 16 : shape_of(t) == 1 ? 32 : 8;
  endfunction
  function automatic int width_of(full_type_t t);
    return 32 >> (int'(t) / 3);
  endfunction
  function automatic logic [2:0] counter_a(full_type_t t);
    return 3'(m_dim(t) / 8);
  endfunction
  function automatic logic [2:0] counter_b(full_type_t t);
    return 3'(n_dim(t) / 8);
  endfunction
  function automatic logic is_int(full_type_t t);
    return width_of(t) <= 8;
  endfunction
  function automatic logic [15:0] ab_bits_of(full_type_t t);
    return 16'(128 * width_of(t));
  endfunction
  function automatic logic [15:0] b_base_of(full_type_t t);
    return 16'(m_dim(t) * K_DIM * width_of(t) / 8);
  endfunction
  function automatic logic [15:0] c_base_of(full_type_t t);
    return b_base_of(t) + 16'(K_DIM * n_dim(t) * width_of(t) / 8);
  endfunction
  function automatic logic [15:0] d_base_of(full_type_t t);
    return c_base_of(t) + 16'(m_dim(t) * n_dim(t) * 4);
  endfunction
  function automatic logic [7:0] burst_num_of(logic [15:0] bits);
    return bits < 16'd512 ? 8'd1 : 8'(bits >> 9);
  endfunction
  // Opens a transfer: keeps the bases of o, sets the request fields for one first-cycle pulse
  function automatic AXI_out_t req(AXI_out_t o, logic [2:0] s, logic [15:0] bits);
    AXI_out_t r;
    r = o;
    r.request_valid = 1'b1;
    r.sel = s;
    r.recvbits = bits;
    r.burst_size = BURST_SIZE;
    r.burst_num = burst_num_of(bits);
    return r;
  endfunction
endpackage

// File: rtl/tc_cfg_decode.sv
// tc_cfg_decode: combinational cfg -> tile counts, INT flag, A/B transfer bits and B/C/D base addresses
module tc_cfg_decode
  import params::*;
(
  input  full_type_t  cfg,
  output logic [2:0]  cnt_a,
  output logic [2:0]  cnt_b,
  output logic        int_type,
  output logic [15:0] ab_bits,
  output logic [15:0] b_base,
  output logic [15:0] c_base,
  output logic [15:0] d_base
);
  assign cnt_a = counter_a(cfg);
  assign cnt_b = counter_b(cfg);
  assign int_type = is_int(cfg);
  assign ab_bits = ab_bits_of(cfg);
  assign b_base = b_base_of(cfg);
  assign c_base = c_base_of(cfg);
  assign d_base = d_base_of(cfg);
endmodule

// File: rtl/tc_seq_ctrl.sv
// tc_seq_ctrl: MMA job sequencer (clk, rst, start, cfg, axi_in -> axi_out, state, a_idx, b_idx, busy, done, cfg_err)
module tc_seq_ctrl
  import params::*;
#(
  parameter int SYS_LAT = 31,
  parameter int ACC_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  full_type_t cfg,
  input  AXI_in_t    axi_in,
  output AXI_out_t   axi_out,
  output state_t     state,
  output logic [1:0] a_idx,
  output logic [1:0] b_idx,
  output logic       busy,
  output logic       done,
  output logic       cfg_err
);
  logic [2:0] cnt_a, cnt_b, dec_a, dec_b;
  logic int_q, dec_int, xfer_done, more_a, more_b;
  logic [15:0] ab_bits, dec_bits, dec_b_base, dec_c_base, dec_d_base;
  logic [7:0] cnt;
  AXI_out_t start_req;
  tc_cfg_decode u_dec (
    .cfg(cfg), .cnt_a(dec_a), .cnt_b(dec_b), .int_type(dec_int), .ab_bits(dec_bits),
    .b_base(dec_b_base), .c_base(dec_c_base), .d_base(dec_d_base)
  );
  assign busy = state != IDLE;
  // request_valid marks the request cycle, so a finish seen then is not a completion
  assign xfer_done = axi_in.finish && !axi_out.request_valid;
  assign more_a = {1'b0, a_idx} < cnt_a - 3'd1;
  assign more_b = {1'b0, b_idx} < cnt_b - 3'd1;
  always_comb begin
    start_req = '0;
    start_req.b_base = dec_b_base;
    start_req.c_base = dec_c_base;
    start_req.d_base = dec_d_base;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      a_idx <= '0;
      b_idx <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      cnt <= '0;
      int_q <= 1'b0;
      ab_bits <= '0;
      done <= 1'b0;
      cfg_err <= 1'b0;
      axi_out <= '0;
    end else begin
      done <= 1'b0;
      cfg_err <= 1'b0;
      axi_out.request_valid <= 1'b0;
      case (state)
        IDLE:
          if (start && cfg > CFG_MAX) cfg_err <= 1'b1;
          else if (start) begin
            cnt_a <= dec_a;
            cnt_b <= dec_b;
            int_q <= dec_int;
            ab_bits <= dec_bits;
            a_idx <= '0;
            b_idx <= '0;
            axi_out <= req(start_req, SEL_C, CD_BITS);
            state <= READ_C;
          end
        READ_C:
          if (xfer_done) begin
            axi_out <= req(axi_out, SEL_A, ab_bits);
            state <= WAIT_A;
          end
        WAIT_A:
          if (xfer_done) begin
            axi_out <= req(axi_out, SEL_B, ab_bits);
            state <= WAIT_B;
          end
        WAIT_B:
          if (xfer_done) begin
            cnt <= 8'(SYS_LAT - 1);
            state <= SYSTOLIC;
          end
        SYSTOLIC, ACCUMULATE:
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else if (state == SYSTOLIC && int_q) begin
            cnt <= 8'(ACC_LAT - 1);
            state <= ACCUMULATE;
          end else if (more_b) begin
            b_idx <= b_idx + 2'd1;
            axi_out <= req(axi_out, SEL_B, ab_bits);
            state <= WAIT_B;
          end else begin
            axi_out <= req(axi_out, SEL_D, CD_BITS);
            state <= WRITE_BACK;
          end
        WRITE_BACK:
          if (xfer_done && more_a) begin
            a_idx <= a_idx + 2'd1;
            b_idx <= '0;
            axi_out <= req(axi_out, SEL_C, CD_BITS);
            state <= READ_C;
          end else if (xfer_done) begin
            a_idx <= '0;
            b_idx <= '0;
            done <= 1'b1;
            state <= FINISH;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/tc_seq_ctrl.md
TC_SEQ_CTRL -- requirements
Module: tc_seq_ctrl

Interface
REQ-001 SYS_LAT, 31, systolic pass length in cycles; legal range 1..255.
REQ-002 ACC_LAT, 4, accumulate length in cycles, applied to INT types only; legal range 1..15.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to run one MMA job.
REQ-006 cfg  input  full_type_t  job type, sampled only on an accepted start.
REQ-007 axi_in  input  AXI_in_t  .finish pulses when the outstanding transfer completes.
REQ-008 axi_out  output  AXI_out_t  transfer request to the AXI engine.
REQ-009 state  output  state_t  current controller state.
REQ-010 a_idx / b_idx  output  2 / 2  current A-tile and B-tile index.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 done / cfg_err  output  1 / 1  one-cycle job-complete pulse / one-cycle illegal-cfg pulse.

Function
REQ-013 start SHALL be accepted only in IDLE; start in any other state SHALL be ignored.
REQ-014 On an accepted start with cfg > 11, state SHALL stay IDLE and cfg_err SHALL pulse the next cycle.
REQ-015 Derived counts from latched cfg SHALL be: counter_A = M/8 (M8→1, M16→2, M32→4); counter_B = N/8 (N8→1, N16→2, N32→4); operand width w = 32/16/8/4 for FP32/FP16/INT8/INT4.
REQ-016 Sequence SHALL be IDLE→READ_C→WAIT_A→WAIT_B→SYSTOLIC→[ACCUMULATE, INT only]→next.
REQ-017 After SYSTOLIC or ACCUMULATE: if b_idx < counter_B-1, increment b_idx and go to WAIT_B; else go to WRITE_BACK.
REQ-018 After WRITE_BACK: if a_idx < counter_A-1, increment a_idx, clear b_idx and go to READ_C; else go to FINISH.
REQ-019 FINISH SHALL last one cycle, pulse done, and go to IDLE; a_idx and b_idx SHALL clear there.
REQ-020 axi_out.request_valid SHALL be high for exactly the first cycle of each READ_C, WAIT_A, WAIT_B and WRITE_BACK visit.
REQ-021 Those four states SHALL exit on the first cycle axi_in.finish=1 after the request cycle; a finish in the request cycle itself, or outside these states, SHALL be ignored.
REQ-022 axi_out.sel SHALL be 001 in READ_C, 100 in WAIT_A, 010 in WAIT_B, 000 in WRITE_BACK, and hold its last value elsewhere.
REQ-023 recvbits SHALL be 128*w for A and B, and 2048 for C and D (C/D always 32-bit).
REQ-024 burst_size SHALL be 16; burst_num SHALL be recvbits/512, minimum 1.
REQ-025 A_BASE SHALL be 0; B_BASE = M*K*w/8; C_BASE = B_BASE + K*N*w/8; D_BASE = C_BASE + M*N*4 (bytes); all SHALL be stable from READ_C until IDLE.
REQ-026 SYSTOLIC SHALL last exactly SYS_LAT cycles; ACCUMULATE SHALL last exactly ACC_LAT cycles, counted by one shared down-counter.

Reset
REQ-027 On rst: state=IDLE; a_idx, b_idx, counters, done, cfg_err = 0; axi_out all-zero.
REQ-028 rst asserted mid-job SHALL abort immediately with no done pulse; a start after rst release SHALL begin a fresh job.

Structure
REQ-029 The counter_A/B, width and base-address lookup SHALL live as functions in package params, alongside full_type_t, state_t, AXI_out_t and AXI_in_t.
REQ-030 The FSM and the cycle counter SHALL stay in tc_seq_ctrl; the natural sub-module is tc_cfg_decode, a combinational cfg→counts/width/bases decoder.

Verification
REQ-031 FP32_m16n16k16, finish returned 3 cycles after each request -> sel order 001,100,010,010,000,001,100,010,010,000; bases 0/1024/2048/3072; recvbits A=4096, burst_num=8; no ACCUMULATE; one done pulse.
REQ-032 INT8_m8n32k16 -> counter_A=1, 4× (WAIT_B→SYSTOLIC 31 cycles→ACCUMULATE 4 cycles), then WRITE_BACK; C_BASE=640, D_BASE=1664; A recvbits=1024, burst_num=2.
REQ-033 INT4_m32n8k16 -> 4 rounds of C,A,B,D; burst_num=1 for A and B, 4 for C and D.
REQ-034 cfg=13 with start -> stays IDLE, cfg_err pulses once, no request_valid.
REQ-035 start during SYSTOLIC, finish in the request cycle, and finish during SYSTOLIC -> all ignored; the sequence is unchanged.
REQ-036 rst pulse during WAIT_B with a_idx=1 -> IDLE, outputs zero, no done; a following start runs a complete job.
